// File: rtl/riscv_imm_stage.sv
// RISC-V immediate/format decode stage with a two-entry (output + skid) buffer.
// Decode is combinational on the input side; every output comes straight from a flop.
module riscv_imm_stage #(
  parameter int IBUS_DATA_WIDTH = 32,
  parameter int DBUS_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IBUS_DATA_WIDTH-1:0] in_instr,
  input  logic [DBUS_DATA_WIDTH-1:0] in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DBUS_DATA_WIDTH-1:0] out_imm,
  output logic [5:0]                 out_fmt,
  output logic [DBUS_DATA_WIDTH-1:0] out_target,
  output logic                       out_target_vld,
  output logic [DBUS_DATA_WIDTH-1:0] out_pc,
  output logic [IBUS_DATA_WIDTH-1:0] out_instr,
  output logic                       out_illegal
);

  localparam int W = DBUS_DATA_WIDTH;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  // One-hot format bits, ordered {J,U,B,S,I,R}
  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  typedef struct packed {
    logic [W-1:0]               imm;
    logic [5:0]                 fmt;
    logic [W-1:0]               target;
    logic                       target_vld;
    logic [W-1:0]               pc;
    logic [IBUS_DATA_WIDTH-1:0] instr;
    logic                       illegal;
  } entry_t;

  entry_t dec;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic         is_shift;
  logic [W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [W-1:0] shamt_w, shamt_xlen;

  always_comb begin
    opcode   = in_instr[6:0];
    funct3   = in_instr[14:12];
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    imm_i = {{(W-12){in_instr[31]}}, in_instr[31:20]};
    imm_s = {{(W-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b = {{(W-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
             in_instr[11:8], 1'b0};
    imm_u = {{(W-32){in_instr[31]}}, in_instr[31:12], 12'b0};
    imm_j = {{(W-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
             in_instr[30:21], 1'b0};

    // Word shifts always use a 5-bit shamt; native shifts use 6 bits on RV64
    shamt_w       = '0;
    shamt_w[4:0]  = in_instr[24:20];
    shamt_xlen    = shamt_w;
    if (W == 64) shamt_xlen[5] = in_instr[25];

    dec            = '0;
    dec.pc         = in_pc;
    dec.instr      = in_instr;

    case (opcode)
      OPC_OP: dec.fmt = FMT_R;
      OPC_LOAD, OPC_JALR: begin
        dec.fmt = FMT_I;
        dec.imm = imm_i;
      end
      OPC_OP_IMM: begin
        dec.fmt = FMT_I;
        dec.imm = is_shift ? shamt_xlen : imm_i;
      end
      OPC_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = imm_s;
      end
      OPC_BRANCH: begin
        dec.fmt        = FMT_B;
        dec.imm        = imm_b;
        dec.target_vld = 1'b1;
      end
      OPC_LUI: begin
        dec.fmt = FMT_U;
        dec.imm = imm_u;
      end
      OPC_AUIPC: begin
        dec.fmt        = FMT_U;
        dec.imm        = imm_u;
        dec.target_vld = 1'b1;
      end
      OPC_JAL: begin
        dec.fmt        = FMT_J;
        dec.imm        = imm_j;
        dec.target_vld = 1'b1;
      end
      OPC_OP_IMM_32: begin
        if (W == 64) begin
          dec.fmt = FMT_I;
          dec.imm = is_shift ? shamt_w : imm_i;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OP_32: begin
        if (W == 64) dec.fmt = FMT_R;
        else         dec.illegal = 1'b1;
      end
      // Also catches instr[1:0] != 2'b11, since every legal opcode ends in 11
      default: dec.illegal = 1'b1;
    endcase

    if (dec.target_vld) dec.target = in_pc + dec.imm;
  end

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_vld_q, out_vld_d;
  logic   skid_vld_q, skid_vld_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    accept     = in_valid && in_ready_q && !flush;

    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || out_ready) begin
      // Output slot frees up: refill from skid first to preserve order
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = dec;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end

    in_ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_vld_q;
  assign out_imm        = out_q.imm;
  assign out_fmt        = out_q.fmt;
  assign out_target     = out_q.target;
  assign out_target_vld = out_q.target_vld;
  assign out_pc         = out_q.pc;
  assign out_instr      = out_q.instr;
  assign out_illegal    = out_q.illegal;

endmodule

// File: tb/tb_riscv_imm_stage.sv
// Directed bench for riscv_imm_stage: an RV64 instance carries most vectors,
// an RV32 instance shares its inputs for the XLEN-dependent cases.
module tb_riscv_imm_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        in_ready, out_valid, out_target_vld, out_illegal;
  logic [63:0] out_imm, out_target, out_pc;
  logic [5:0]  out_fmt;
  logic [31:0] out_instr;

  logic        r32_in_ready, r32_out_valid, r32_target_vld, r32_illegal;
  logic [31:0] r32_imm, r32_target, r32_pc, r32_instr;
  logic [5:0]  r32_fmt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_imm_stage #(.IBUS_DATA_WIDTH(32), .DBUS_DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target),
    .out_target_vld(out_target_vld), .out_pc(out_pc), .out_instr(out_instr),
    .out_illegal(out_illegal)
  );

  riscv_imm_stage #(.IBUS_DATA_WIDTH(32), .DBUS_DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(r32_out_valid), .out_ready(out_ready),
    .out_imm(r32_imm), .out_fmt(r32_fmt), .out_target(r32_target),
    .out_target_vld(r32_target_vld), .out_pc(r32_pc), .out_instr(r32_instr),
    .out_illegal(r32_illegal)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle transfer with out_ready=1, then check the RV64 outputs
  task automatic send64(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                        input logic [63:0] imm, input logic [5:0] fmt,
                        input logic [63:0] tgt, input logic tvld, input logic ill);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_val({tag, ".valid"}, 64'(out_valid), 64'd1);
    check_val({tag, ".imm"}, out_imm, imm);
    check_val({tag, ".fmt"}, 64'(out_fmt), 64'(fmt));
    check_val({tag, ".target"}, out_target, tgt);
    check_val({tag, ".tvld"}, 64'(out_target_vld), 64'(tvld));
    check_val({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
    check_val({tag, ".pc"}, out_pc, pc);
    check_val({tag, ".instr"}, 64'(out_instr), 64'(instr));
    $display("txn %s instr=%08h imm=%016h fmt=%06b tgt=%016h", tag, instr, out_imm, out_fmt, out_target);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    tick(); tick();
    check_val("rst.out_valid", 64'(out_valid), 64'd0);
    check_val("rst.in_ready", 64'(in_ready), 64'd0);
    check_val("rst.out_imm", out_imm, 64'd0);
    #2 rst = 1'b0;
    tick();
    check_val("post_rst.in_ready", 64'(in_ready), 64'd1);
    check_val("post_rst.out_valid", 64'(out_valid), 64'd0);

    send64("addi_m1", 32'hFFF00093, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 6'b000010, 64'h0, 1'b0, 1'b0);
    send64("srai3",   32'h4033D093, 64'h4, 64'd3, 6'b000010, 64'h0, 1'b0, 1'b0);
    send64("lui",     32'h80000037, 64'h8, 64'hFFFF_FFFF_8000_0000, 6'b010000, 64'h0, 1'b0, 1'b0);
    send64("beq_m4",  32'hFE000EE3, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFC, 6'b001000,
           64'h8000_000C, 1'b1, 1'b0);
    send64("jal8",    32'h008000EF, 64'h1000, 64'd8, 6'b100000, 64'h1008, 1'b1, 1'b0);
    send64("auipc",   32'h00001097, 64'h2000, 64'h1000, 6'b010000, 64'h3000, 1'b1, 1'b0);
    send64("jalr4",   32'h00408067, 64'h5000, 64'd4, 6'b000010, 64'h0, 1'b0, 1'b0);
    send64("sw_m8",   32'hFE20AC23, 64'h6000, 64'hFFFF_FFFF_FFFF_FFF8, 6'b000100, 64'h0, 1'b0, 1'b0);
    send64("add",     32'h002081B3, 64'h7000, 64'h0, 6'b000001, 64'h0, 1'b0, 1'b0);
    send64("addw",    32'h002081BB, 64'h7004, 64'h0, 6'b000001, 64'h0, 1'b0, 1'b0);
    send64("slliw",   32'h0250909B, 64'h7008, 64'd5, 6'b000010, 64'h0, 1'b0, 1'b0);
    send64("badlsb",  32'h00000010, 64'h700C, 64'h0, 6'b000000, 64'h0, 1'b0, 1'b1);

    // slli with instr[25] set: 6-bit shamt on RV64, 5-bit on RV32
    send64("slli35",  32'h02309093, 64'h7010, 64'd35, 6'b000010, 64'h0, 1'b0, 1'b0);
    check_val("r32.slli.imm", 64'(r32_imm), 64'd3);
    send64("zero",    32'h00000000, 64'h7014, 64'h0, 6'b000000, 64'h0, 1'b0, 1'b1);
    check_val("r32.zero.illegal", 64'(r32_illegal), 64'd1);
    check_val("r32.zero.fmt", 64'(r32_fmt), 64'd0);
    check_val("r32.zero.imm", 64'(r32_imm), 64'd0);
    send64("op32",    32'h0000003B, 64'h7018, 64'h0, 6'b000001, 64'h0, 1'b0, 1'b0);
    check_val("r32.op32.illegal", 64'(r32_illegal), 64'd1);
    check_val("r32.op32.fmt", 64'(r32_fmt), 64'd0);
    check_val("r32.op32.imm", 64'(r32_imm), 64'd0);

    // Back-to-back streaming with out_ready=1: one entry per cycle
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = 32'h00000093 | (32'(i + 1) << 20);
      tick();
      check_val($sformatf("stream%0d.instr", i), 64'(out_instr), 64'(32'h00000093 | (32'(i + 1) << 20)));
      check_val($sformatf("stream%0d.imm", i), out_imm, 64'(i + 1));
      check_val($sformatf("stream%0d.in_ready", i), 64'(in_ready), 64'd1);
      $display("txn stream%0d instr=%08h", i, out_instr);
    end
    in_valid = 1'b0;
    tick();
    check_val("stream.drain", 64'(out_valid), 64'd0);

    // Stall: 4 edges with out_ready=0 while three inputs are offered
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
    tick();
    check_val("stall.A.in_ready", 64'(in_ready), 64'd1);
    in_instr = 32'h00200093;
    tick();
    check_val("stall.B.in_ready", 64'(in_ready), 64'd0);
    in_instr = 32'h00300093;
    tick(); tick();
    check_val("stall.hold.in_ready", 64'(in_ready), 64'd0);
    check_val("stall.hold.valid", 64'(out_valid), 64'd1);
    check_val("stall.hold.instr", 64'(out_instr), 64'h00100093);
    check_val("stall.hold.imm", out_imm, 64'd1);
    out_ready = 1'b1;
    tick();
    check_val("release.B", 64'(out_instr), 64'h00200093);
    check_val("release.in_ready", 64'(in_ready), 64'd1);
    tick();
    check_val("release.C", 64'(out_instr), 64'h00300093);
    check_val("release.C.valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    check_val("release.drain", 64'(out_valid), 64'd0);
    $display("txn stall_release A,B,C in order");

    // Flush with both entries full and a new input offered
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00A00093;
    tick();
    in_instr = 32'h00B00093;
    tick();
    check_val("flush.pre.in_ready", 64'(in_ready), 64'd0);
    in_instr = 32'h00C00093; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush.out_valid", 64'(out_valid), 64'd0);
    check_val("flush.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("flush.gone%0d", i), 64'(out_valid), 64'd0);
    end
    $display("txn flush discarded two buffered entries");

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h1234;
    tick();
    in_instr = 32'h00D00093;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("arst.out_valid", 64'(out_valid), 64'd0);
    check_val("arst.in_ready", 64'(in_ready), 64'd0);
    check_val("arst.out_imm", out_imm, 64'd0);
    check_val("arst.out_pc", out_pc, 64'd0);
    check_val("arst.out_instr", 64'(out_instr), 64'd0);
    check_val("arst.out_fmt", 64'(out_fmt), 64'd0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("arst.after.in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("arst.none%0d", i), 64'(out_valid), 64'd0);
      tick();
    end
    $display("txn reset mid-stall discarded entries");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_imm_stage.md
RISCV_IMM_STAGE -- requirements
Module: riscv_imm_stage

Interface
REQ-001 SHALL have parameter IBUS_DATA_WIDTH, default 32, instruction width; only 32 is legal.
REQ-002 SHALL have parameter DBUS_DATA_WIDTH, default 64, XLEN; legal values are 32 and 64.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port flush, input, 1, discards all buffered entries.
REQ-006 SHALL have port in_valid, input, 1, upstream entry present.
REQ-007 SHALL have port in_ready, output, 1, stage can accept an entry.
REQ-008 SHALL have port in_instr, input, IBUS_DATA_WIDTH, instruction.
REQ-009 SHALL have port in_pc, input, DBUS_DATA_WIDTH, instruction address.
REQ-010 SHALL have port out_valid, output, 1, decoded entry present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts.
REQ-012 SHALL have port out_imm, output, DBUS_DATA_WIDTH, extended immediate.
REQ-013 SHALL have port out_fmt, output, 6, one-hot {J,U,B,S,I,R}; all-zero means no format.
REQ-014 SHALL have port out_target, output, DBUS_DATA_WIDTH, pc-relative target.
REQ-015 SHALL have port out_target_vld, output, 1, out_target meaningful.
REQ-016 SHALL have ports out_pc (DBUS_DATA_WIDTH), out_instr (IBUS_DATA_WIDTH) and out_illegal (1), all outputs, passed-through pc, passed-through instruction, and undecodable flag.

Function
REQ-017 SHALL decode the format from instr[6:0]:
- 0110011 gives R.
- 0000011, 0010011 and 1100111 give I.
- 0100011 gives S.
- 1100011 gives B.
- 0110111 and 0010111 give U.
- 1101111 gives J.
- 0011011 gives I and 0111011 gives R, only when DBUS_DATA_WIDTH=64.
REQ-018 SHALL flag out_illegal=1, out_fmt=0 and out_imm=0 for any other opcode, or when instr[1:0]!=2'b11.
REQ-019 SHALL form immediates as follows:
- I: instr[31:20].
- S: {instr[31:25],instr[11:7]}.
- B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
- U: {instr[31:12],12'b0}.
- J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
- All are sign-extended from their MSB to DBUS_DATA_WIDTH.
- R: imm=0.
REQ-020 SHALL, for opcode 0010011 with funct3 001/101, output a zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-021 SHALL, for opcode 0011011 with funct3 001/101, output zero-extended instr[24:20].
REQ-022 SHALL compute out_target = pc + imm modulo 2^DBUS_DATA_WIDTH, with out_target_vld=1, for B, J and AUIPC (0010111) only.
REQ-023 SHALL drive out_target=0 and out_target_vld=0 for all other opcodes, including JALR.
REQ-024 SHALL register all outputs, with latency exactly 1 cycle from in_valid&&in_ready to out_valid when the stage is empty.
REQ-025 SHALL hold two entries: an output register plus a skid register.
REQ-026 SHALL derive in_ready=1 iff the skid register is empty, from a register only; in_ready has no combinational path from out_ready.
REQ-027 SHALL sustain a throughput of 1 entry/cycle while out_ready=1.
REQ-028 SHALL keep all out_* stable while out_valid=1 and out_ready=0.
REQ-029 SHALL deliver entries in acceptance order, with no loss and no duplication.
REQ-030 SHALL, when the output is accepted while the skid is full, move the skid entry to the output at the next edge; an input accepted in the same cycle enters the skid.
REQ-031 SHALL, when flush=1, empty both entries at the next edge.
REQ-032 SHALL ignore in_valid during the flush cycle, with no entry accepted.
REQ-033 SHALL give flush priority over all simultaneous handshakes.

Reset
REQ-034 SHALL, while rst=1, force out_valid=0 and in_ready=0, with both entries empty.
REQ-035 SHALL, while rst=1, force out_imm, out_fmt, out_target, out_target_vld, out_pc, out_instr and out_illegal to 0.
REQ-036 SHALL set in_ready=1 on the first rising edge after rst deasserts.
REQ-037 SHALL treat rst asserted mid-stall as discarding all entries, with no entry delivered afterwards.

Verification
REQ-038 SHALL cover: XLEN=64, in_instr=0xFFF00093 (addi -1) -> next cycle out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=6'b000010, out_target_vld=0.
REQ-039 SHALL cover: XLEN=64, 0x4033D093 (srai x1,x7,3) -> out_imm=3; XLEN=64, 0x80000037 (lui) -> out_imm=0xFFFFFFFF80000000, out_fmt=6'b010000.
REQ-040 SHALL cover: 0xFE000EE3 (beq -4) with pc=0x80000010 -> out_imm=-4, out_target=0x8000000C, out_target_vld=1.
REQ-041 SHALL cover: out_ready=0 for 4 cycles with 3 back-to-back inputs -> 2 accepted, in_ready=0 from the 3rd edge; after release, outputs appear in order on consecutive cycles, then the 3rd is accepted.
REQ-042 SHALL cover: flush asserted while both entries are full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed entries never appear.
REQ-043 SHALL cover: 0x00000000 and 0x0000003B at XLEN=32 -> out_illegal=1, out_fmt=0, out_imm=0; rst pulse mid-stall -> all outputs 0 asynchronously.
